spi_target: RTL and testbench

//  SPI responder (mode 0, MSB first): the far end of our SPI master link, for talking to a host MCU/bridge.
//  SPI pins are asynchronous to clock; the block oversamples them through synchronisers.

---
 rtl/spi_target_pkg.sv | 8 +
 rtl/spi_target_if.sv | 14 +
 rtl/spi_target_sync_ff.sv | 16 +
 rtl/spi_target.sv | 76 +++++++
 tb/tb_spi_target.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared state type and SPI mode constants for the SPI responder
package spi_target_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic SPI_CPOL = SPI_MODE[1];
  localparam logic CS_IDLE = 1'b1;
  localparam logic [7:0] FILL_DEFAULT = 8'hFF;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins plus byte-level TX/RX core handshake
interface spi_target_if #(parameter int W = 8);
  logic spi_clk, spi_cs_n, spi_mosi, spi_miso, spi_miso_en;
  logic [W-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, tx_underrun, frame_start, frame_end;
  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_en, tx_ready, rx_data, rx_valid, tx_underrun, frame_start, frame_end
  );
  modport master (
    output spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_en, tx_ready, rx_data, rx_valid, tx_underrun, frame_start, frame_end
  );
endinterface

// File: rtl/spi_target_sync_ff.sv
// sync_ff: flop-chain synchroniser with a selectable reset level
module sync_ff #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r <= {STAGES{RST_VAL}};
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/spi_target.sv
// spi_target: oversampling SPI mode-0 responder with a 1-entry TX buffer and RX byte strobe
module spi_target
  import spi_target_pkg::*;
#(
  parameter int W = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [W-1:0] FILL_BYTE = FILL_DEFAULT
) (
  input logic clock,
  input logic reset_n,
  spi_target_if.slave bus
);
  localparam int CW = $clog2(W);
  logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0] tx_shift, buf_data, rx_data;
  logic [W-2:0] rx_shift;
  logic buf_full, rx_valid, tx_underrun, frame_start, frame_end;
  logic start_f, end_f, rise, fall, last, load, accept;
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk (.clock, .reset_n, .d(bus.spi_clk), .q(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs (.clock, .reset_n, .d(bus.spi_cs_n), .q(cs_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clock, .reset_n, .d(bus.spi_mosi), .q(mosi_s));
  // CS deassertion masks any SCLK edge seen in the same cycle
  always_comb begin
    start_f = state == IDLE && cs_q && !cs_s;
    end_f = state == ACTIVE && !cs_q && cs_s;
    rise = state == ACTIVE && !end_f && sclk_s && !sclk_q;
    fall = state == ACTIVE && !end_f && !sclk_s && sclk_q;
    last = bit_cnt == CW'(W-1);
    load = start_f || (fall && bit_cnt == '0);
    accept = bus.tx_valid && !buf_full;
    state_nx = start_f ? ACTIVE : end_f ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sclk_q <= SPI_CPOL;
      cs_q <= CS_IDLE;
      bit_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      state <= state_nx;
      sclk_q <= sclk_s;
      cs_q <= cs_s;
      rx_valid <= rise && last;
      tx_underrun <= load && !buf_full;
      frame_start <= start_f;
      frame_end <= end_f;
      buf_full <= accept || (buf_full && !load);
      if (accept) buf_data <= bus.tx_data;
      if (start_f || end_f) bit_cnt <= '0;
      else if (rise) bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      if (rise) rx_shift <= {rx_shift[W-3:0], mosi_s};
      if (rise && last) rx_data <= {rx_shift, mosi_s};
      // a load while the buffer is empty sends the fill word instead
      if (load) tx_shift <= buf_full ? buf_data : FILL_BYTE;
      else if (fall) tx_shift <= tx_shift << 1;
    end
  assign bus.spi_miso = state == ACTIVE && tx_shift[W-1];
  assign bus.spi_miso_en = state == ACTIVE;
  assign bus.tx_ready = !buf_full;
  assign bus.rx_data = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.tx_underrun = tx_underrun;
  assign bus.frame_start = frame_start;
  assign bus.frame_end = frame_end;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: table-driven and randomized checks of spi_target against a byte-level host model
module tb_spi_target;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  spi_target_if bus ();
  spi_target dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  int rx_cnt = 0, und_cnt = 0, fs_cnt = 0, fe_cnt = 0;

  always @(negedge clock) begin
    if (bus.rx_valid) rx_cnt++;
    if (bus.tx_underrun) und_cnt++;
    if (bus.frame_start) fs_cnt++;
    if (bus.frame_end) fe_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] host;
    bit         queued;
    logic [7:0] txb;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int t;
    t = 0;
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got ready=0, want ready=1 within 500 cycles");
    end
    @(negedge clock);
    bus.tx_valid = 1'b0;
  endtask

  task automatic host_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = tx[7-i];
      repeat (4) @(negedge clock);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      repeat (4) @(negedge clock);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clock);
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    vec_t tbl[5];
    logic [7:0] g, g1, g2, hb, txb;
    logic [7:0] got5[3];
    int s_rx, s_und, s_fs, s_fe, nw, q;
    bus.spi_clk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    tbl[0] = '{8'h3C, 1'b1, 8'hA5, 8'hA5, 8'h3C, 1};
    tbl[1] = '{8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 2};
    tbl[2] = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF, 1};
    tbl[3] = '{8'h81, 1'b1, 8'h7E, 8'h7E, 8'h81, 1};
    tbl[4] = '{8'hC3, 0, 8'h00, 8'hFF, 8'hC3, 2};

    // reset held: SCLK activity must not disturb outputs
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clock);
      bus.spi_clk = ~bus.spi_clk;
      bus.spi_mosi = ~bus.spi_mosi;
      check("rst_tx_ready", bus.tx_ready, 1);
      check("rst_miso_en", bus.spi_miso_en, 0);
      check("rst_miso", bus.spi_miso, 0);
      check("rst_rx_valid", bus.rx_valid, 0);
    end
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("rst_rx_data", bus.rx_data, 0);
    check("no_spurious_frame", fs_cnt + fe_cnt, 0);

    // single-word frames from the vector table
    foreach (tbl[i]) begin
      s_rx = rx_cnt; s_und = und_cnt; s_fs = fs_cnt; s_fe = fe_cnt;
      if (tbl[i].queued) push(tbl[i].txb);
      cs_low();
      host_bits(tbl[i].host, 8, g);
      cs_high();
      check("tbl_miso", g, tbl[i].exp_miso);
      check("tbl_rx_data", bus.rx_data, tbl[i].exp_rx);
      check("tbl_rx_valid_cnt", rx_cnt - s_rx, 1);
      check("tbl_underrun_cnt", und_cnt - s_und, tbl[i].exp_und);
      check("tbl_frame_start", fs_cnt - s_fs, 1);
      check("tbl_frame_end", fe_cnt - s_fe, 1);
    end

    // one queued word, two words clocked: second word is the fill byte
    s_und = und_cnt;
    push(8'h01);
    cs_low();
    host_bits(8'h11, 8, g1);
    repeat (4) @(negedge clock);
    check("und_at_word2", und_cnt - s_und, 1);
    host_bits(8'h22, 8, g2);
    cs_high();
    check("two_word_w1", g1, 8'h01);
    check("two_word_w2", g2, 8'hFF);
    check("two_word_rx", bus.rx_data, 8'h22);
    check("two_word_und_total", und_cnt - s_und, 2);

    // CS rises after 5 bits: partial word dropped, next frame intact
    s_rx = rx_cnt; s_fe = fe_cnt;
    cs_low();
    host_bits(8'hB4, 5, g);
    cs_high();
    check("partial_no_rx_valid", rx_cnt - s_rx, 0);
    check("partial_frame_end", fe_cnt - s_fe, 1);
    push(8'h99);
    cs_low();
    host_bits(8'h81, 8, g);
    cs_high();
    check("after_partial_rx", bus.rx_data, 8'h81);
    check("after_partial_rx_cnt", rx_cnt - s_rx, 1);
    check("after_partial_miso", g, 8'h99);

    // streaming with tx_valid held while the buffer is full
    push(8'h10);
    check("ready_low_full", bus.tx_ready, 0);
    fork
      begin
        push(8'h20);
        push(8'h30);
      end
      begin
        cs_low();
        for (int k = 0; k < 3; k++) host_bits(8'h40 + 8'(k), 8, got5[k]);
        cs_high();
      end
    join
    check("stream_w0", got5[0], 8'h10);
    check("stream_w1", got5[1], 8'h20);
    check("stream_w2", got5[2], 8'h30);
    check("stream_rx", bus.rx_data, 8'h42);

    // asynchronous reset mid-word
    cs_low();
    push(8'h66);
    host_bits(8'h5A, 3, g);
    check("pre_rst_ready", bus.tx_ready, 0);
    check("pre_rst_miso_en", bus.spi_miso_en, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_miso_en", bus.spi_miso_en, 0);
    check("async_rst_miso", bus.spi_miso, 0);
    check("async_rst_ready", bus.tx_ready, 1);
    check("async_rst_rx_valid", bus.rx_valid, 0);
    bus.spi_cs_n = 1'b1;
    bus.spi_clk = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    s_rx = rx_cnt; s_fs = fs_cnt;
    cs_low();
    host_bits(8'hC6, 8, g);
    cs_high();
    check("post_rst_miso", g, 8'hFF);
    check("post_rst_rx", bus.rx_data, 8'hC6);
    check("post_rst_rx_cnt", rx_cnt - s_rx, 1);
    check("post_rst_frame_start", fs_cnt - s_fs, 1);

    // randomized frames against the byte-level model
    for (int r = 0; r < 12; r++) begin
      nw = $urandom_range(1, 3);
      q = $urandom_range(0, 1);
      txb = 8'($urandom);
      s_rx = rx_cnt; s_und = und_cnt;
      if (q == 1) push(txb);
      cs_low();
      for (int w = 0; w < nw; w++) begin
        hb = 8'($urandom);
        host_bits(hb, 8, g);
        check("rnd_miso", g, (w == 0 && q == 1) ? txb : 8'hFF);
        check("rnd_rx", bus.rx_data, hb);
      end
      cs_high();
      check("rnd_rx_cnt", rx_cnt - s_rx, nw);
      check("rnd_und_cnt", und_cnt - s_und, 1 + nw - q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
